// File: rtl/digit_scan_mux.sv
// Scanner for an N-digit common-anode 7-segment display.
// It double-buffers the frame, blanks all anodes at the start of each slot and can suppress leading zeros.

module digit_scan_lane #(
    parameter int unsigned LANE  = 0,
    parameter int unsigned IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             blank_i,
    input  logic             lz_en_i,
    input  logic             run_zero_i,
    input  logic [3:0]       code_i,
    output logic             an_n_o,
    output logic [3:0]       code_o
);

    assign an_n_o = blank_i | (idx_i != IDX_W'(LANE));
    assign code_o = (lz_en_i & run_zero_i) ? 4'hF : code_i;

endmodule

module digit_scan_mux #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] digits_in_i,
    input  logic                    load_i,
    input  logic                    lz_en_i,
    output logic [3:0]              bcd_out_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_done_o,
    output logic                    updated_o
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_V  = DIV_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][3:0] frame_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [3:0]            bcd;
        logic                  frame_done;
        logic                  updated;
    } scan_out_t;

    localparam scan_out_t OUT_RST = '{an: '1, bcd: 4'hF, frame_done: 1'b0, updated: 1'b0};

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    frame_t           pend_q, pend_d;
    frame_t           disp_q, disp_d;
    logic             pend_vld_q, pend_vld_d;
    scan_out_t        out_q, out_d;

    frame_t                din_w;
    frame_t                eff_code;
    logic [NUM_DIGITS-1:0] an_n;
    logic [NUM_DIGITS:1]   zrun;
    logic                  tick, boundary, blank;

    assign din_w    = digits_in_i;
    assign tick     = (div_cnt_q == DIV_LAST);
    assign boundary = tick & (idx_q == IDX_LAST);
    assign blank    = (div_cnt_q < BLANK_V);

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Transfer uses the pending frame as it was before this cycle's load,
    // so a load on the boundary lands in pending for the following frame.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        if (boundary && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end
        if (load_i) begin
            pend_d     = din_w;
            pend_vld_d = 1'b1;
        end
    end

    // zrun[k]: display digits NUM_DIGITS-1..k are all zero.
    assign zrun[NUM_DIGITS] = 1'b1;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
        logic run_zero;
        if (k == 0) begin : g_lsd
            assign run_zero = 1'b0;
        end else begin : g_upper
            assign zrun[k]  = zrun[k+1] & (disp_q[k] == 4'h0);
            assign run_zero = zrun[k];
        end

        digit_scan_lane #(
            .LANE  (k),
            .IDX_W (IDX_W)
        ) u_lane (
            .idx_i      (idx_q),
            .blank_i    (blank),
            .lz_en_i    (lz_en_i),
            .run_zero_i (run_zero),
            .code_i     (disp_q[k]),
            .an_n_o     (an_n[k]),
            .code_o     (eff_code[k])
        );
    end

    always_comb begin
        out_d            = OUT_RST;
        out_d.an         = an_n;
        out_d.bcd        = eff_code[idx_q];
        out_d.frame_done = boundary;
        out_d.updated    = boundary & pend_vld_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q  <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            disp_q     <= '1;
            out_q      <= OUT_RST;
        end else begin
            div_cnt_q  <= div_cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            disp_q     <= disp_d;
            out_q      <= out_d;
        end
    end

    assign an_o         = out_q.an;
    assign bcd_out_o    = out_q.bcd;
    assign frame_done_o = out_q.frame_done;
    assign updated_o    = out_q.updated;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Randomized bench for digit_scan_mux against a cycle-count based reference model.
module tb_digit_scan_mux;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = N * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        frame_done;
    logic        updated;

    int n_vec = 0;
    int n_err = 0;

    // model state: cycles since reset release, shown frame, pending frame
    int         cyc = 0;
    logic [3:0] m_disp [N];
    logic [3:0] m_pend [N];
    logic       m_pv = 1'b0;
    int         upd_cnt = 0;

    always #5 clk = ~clk;

    digit_scan_mux #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .digits_in_i  (digits_in),
        .load_i       (load),
        .lz_en_i      (lz_en),
        .bcd_out_o    (bcd_out),
        .an_o         (an),
        .frame_done_o (frame_done),
        .updated_o    (updated)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc  = 0;
        m_pv = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_disp[k] = 4'hF;
            m_pend[k] = 4'h0;
        end
    endtask

    // One clock: drive inputs, predict, clock, compare, advance model.
    task automatic step(input logic ld, input logic [15:0] din);
        int         div, idx, hi;
        logic       bnd;
        logic [3:0] e_an, e_bcd;
        load      = ld;
        digits_in = din;
        div = cyc % RD;
        idx = (cyc / RD) % N;
        e_an = (div < BC) ? 4'hF : ~(4'b0001 << idx);
        hi = -1;
        for (int k = 0; k < N; k++) if (m_disp[k] != 4'h0) hi = k;
        e_bcd = (lz_en && idx != 0 && idx > hi) ? 4'hF : m_disp[idx];
        bnd = (div == RD - 1) && (idx == N - 1);
        @(posedge clk);
        #1;
        chk("an", 16'(an), 16'(e_an));
        chk("bcd", 16'(bcd_out), 16'(e_bcd));
        chk("frame_done", 16'(frame_done), 16'(bnd));
        chk("updated", 16'(updated), 16'(bnd && m_pv));
        if (updated) upd_cnt++;
        if (bnd && m_pv) begin
            for (int k = 0; k < N; k++) m_disp[k] = m_pend[k];
            m_pv = 1'b0;
        end
        if (ld) begin
            for (int k = 0; k < N; k++) m_pend[k] = din[4*k +: 4];
            m_pv = 1'b1;
        end
        cyc++;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 16'h0);
    endtask

    // Advance until the next predicted cycle sits at the given frame phase.
    task automatic sync_to(input int ph);
        while ((cyc % FRAME) != ph) step(1'b0, 16'h0);
    endtask

    function automatic logic [15:0] rand_frame();
        logic [15:0] f;
        for (int k = 0; k < N; k++)
            f[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return f;
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_bcd", 16'(bcd_out), 16'hF);
        chk("rst_fd", 16'(frame_done), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic frame and blanking
        step(1'b1, 16'h4321);
        run(3 * FRAME);

        // double buffer: two loads in one frame, one transfer
        sync_to(1);
        upd_cnt = 0;
        step(1'b1, 16'h1111);
        run(6);
        step(1'b1, 16'h2222);
        run(2 * FRAME);
        chk("upd_once", 16'(upd_cnt), 16'd1);

        // load coincident with the boundary
        sync_to(2);
        step(1'b1, 16'h5555);
        sync_to(FRAME - 1);
        step(1'b1, 16'h6666);
        run(2 * FRAME);

        // leading-zero suppression
        lz_en = 1'b1;
        step(1'b1, 16'h0070);
        run(2 * FRAME);
        step(1'b1, 16'h0000);
        run(2 * FRAME);
        step(1'b1, 16'h00A0);
        run(2 * FRAME);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 40) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 19) == 0) step(1'b1, rand_frame());
            else                            step(1'b0, 16'h0);
        end

        // asynchronous reset in the middle of slot 2
        step(1'b1, 16'h9876);
        sync_to(2 * RD + 4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_an", 16'(an), 16'hF);
        chk("arst_bcd", 16'(bcd_out), 16'hF);
        chk("arst_fd", 16'(frame_done), 16'h0);
        chk("arst_upd", 16'(updated), 16'h0);
        model_reset();
        lz_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(3 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
